// File: rtl/async_fifo_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO: write-pointer synchroniser, read pointer,
// BRAM read strobe and a first-word-fall-through output register.
module async_fifo_rd_ctrl #(
  parameter int WIDTH       = 8,
  parameter int PTR_LEN     = 3,
  parameter int SIZE        = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               rd_clk,
  input  logic               rd_arstn,
  input  logic [PTR_LEN:0]   wr_ptr_gray,
  output logic [PTR_LEN:0]   rd_ptr_gray,
  output logic [PTR_LEN:0]   read_ptr,
  output logic               rd_en,
  input  logic [WIDTH-1:0]   rd_data,
  output logic [WIDTH-1:0]   m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               empty,
  output logic [PTR_LEN:0]   rd_level,
  output logic               ptr_err
);

  localparam int PW = PTR_LEN + 1;

  // Index 0 samples the asynchronous pointer; the last stage is the usable copy.
  logic [SYNC_STAGES-1:0][PW-1:0] r_sync;
  logic [PW-1:0]                  w_wq_gray;
  logic [PW-1:0]                  w_wq_bin;

  logic [PW-1:0]    r_rd_ptr_bin;
  logic [PW-1:0]    r_rd_ptr_gray;
  logic [PW-1:0]    w_next_bin;
  logic [PW-1:0]    w_level;
  logic             w_empty;
  logic             w_fetch;
  logic [WIDTH-1:0] r_m_data;
  logic             r_m_valid;
  logic             r_ptr_err;

  always_ff @(posedge rd_clk or negedge rd_arstn) begin
    if (!rd_arstn) r_sync <= '0;
    else           r_sync <= {r_sync[SYNC_STAGES-2:0], wr_ptr_gray};
  end

  assign w_wq_gray = r_sync[SYNC_STAGES-1];

  for (genvar i = 0; i < PW; i++) begin : g_g2b
    assign w_wq_bin[i] = ^w_wq_gray[PW-1:i];
  end

  assign w_empty    = (r_rd_ptr_bin == w_wq_bin);
  assign w_level    = w_wq_bin - r_rd_ptr_bin;
  // Refill whenever the output register is free or being drained this cycle.
  assign w_fetch    = !w_empty && (!r_m_valid || m_ready);
  assign w_next_bin = r_rd_ptr_bin + PW'(w_fetch);

  always_ff @(posedge rd_clk or negedge rd_arstn) begin
    if (!rd_arstn) begin
      r_rd_ptr_bin  <= '0;
      r_rd_ptr_gray <= '0;
    end else begin
      r_rd_ptr_bin  <= w_next_bin;
      r_rd_ptr_gray <= w_next_bin ^ (w_next_bin >> 1);
    end
  end

  always_ff @(posedge rd_clk or negedge rd_arstn) begin
    if (!rd_arstn) begin
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
    end else if (w_fetch) begin
      r_m_data  <= rd_data;
      r_m_valid <= 1'b1;
    end else if (m_ready && r_m_valid) begin
      r_m_valid <= 1'b0;
    end
  end

  // A level above the depth can only come from a corrupted pointer pair.
  always_ff @(posedge rd_clk or negedge rd_arstn) begin
    if (!rd_arstn)               r_ptr_err <= 1'b0;
    else if (w_level > PW'(SIZE)) r_ptr_err <= 1'b1;
  end

  assign rd_ptr_gray = r_rd_ptr_gray;
  assign read_ptr    = r_rd_ptr_bin;
  assign rd_en       = w_fetch;
  assign m_data      = r_m_data;
  assign m_valid     = r_m_valid;
  assign empty       = w_empty;
  assign rd_level    = w_level;
  assign ptr_err     = r_ptr_err;

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Bench for async_fifo_rd_ctrl: directed latency/backpressure/reset/error steps plus a
// randomized producer/consumer stream checked against a queue of written words.
module tb_async_fifo_rd_ctrl;
  localparam int W  = 8;
  localparam int PL = 3;
  localparam int PW = PL + 1;

  logic          rd_clk = 1'b0;
  logic          rd_arstn = 1'b1;
  logic [PW-1:0] wr_ptr_gray = '0;
  logic [PW-1:0] rd_ptr_gray, read_ptr, rd_level;
  logic          rd_en, m_valid, empty, ptr_err;
  logic          m_ready = 1'b0;
  logic [W-1:0]  rd_data, m_data;

  logic [W-1:0]  mem [0:7];
  logic [W-1:0]  exp_q [$];
  int            wp = 0;
  int            n_pass = 0;
  int            n_total = 0;

  async_fifo_rd_ctrl #(.WIDTH(W), .PTR_LEN(PL), .SIZE(8), .SYNC_STAGES(2)) dut (
    .rd_clk(rd_clk), .rd_arstn(rd_arstn), .wr_ptr_gray(wr_ptr_gray),
    .rd_ptr_gray(rd_ptr_gray), .read_ptr(read_ptr), .rd_en(rd_en), .rd_data(rd_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .empty(empty),
    .rd_level(rd_level), .ptr_err(ptr_err)
  );

  always #5 rd_clk = ~rd_clk;

  // BRAM model: combinational read, zero when not enabled.
  assign rd_data = rd_en ? mem[read_ptr[PL-1:0]] : '0;

  function automatic logic [PW-1:0] gray(int b);
    logic [PW-1:0] x;
    x = PW'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic push(logic [W-1:0] d);
    mem[wp % 8] = d;
    exp_q.push_back(d);
    wp++;
    wr_ptr_gray = gray(wp);
  endtask

  task automatic do_reset();
    rd_arstn = 1'b0;
    wp = 0;
    wr_ptr_gray = '0;
    m_ready = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rd_arstn = 1'b1;
  endtask

  task automatic wait_valid(string tag);
    int k = 0;
    while (!m_valid && k < 20) begin
      tick();
      k++;
    end
    chk(tag, 32'(m_valid), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ntx, nrd;
    logic [PW-1:0] pg;
    logic [W-1:0]  sd;
    bit stall, wrapped;

    for (int i = 0; i < 8; i++) mem[i] = '0;
    #2;
    rd_arstn = 1'b0;
    tick();
    tick();
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_rd_level", 32'(rd_level), 0);
    chk("rst_rd_ptr_gray", 32'(rd_ptr_gray), 0);
    chk("rst_ptr_err", 32'(ptr_err), 0);
    rd_arstn = 1'b1;

    // First word: pointer moves before edge N, word visible after N+2.
    push(8'hA5);
    tick();
    chk("fw_empty_n", 32'(empty), 1);
    tick();
    chk("fw_empty_n1", 32'(empty), 0);
    chk("fw_level_n1", 32'(rd_level), 1);
    chk("fw_rd_en_n1", 32'(rd_en), 1);
    tick();
    chk("fw_valid_n2", 32'(m_valid), 1);
    chk("fw_data_n2", 32'(m_data), 'hA5);
    chk("fw_gray_n2", 32'(rd_ptr_gray), 1);
    m_ready = 1'b1;
    tick();
    chk("fw_consumed", 32'(m_valid), 0);

    // Streaming a full FIFO at one word per cycle.
    do_reset();
    for (int i = 0; i < 8; i++) push(W'(8'h10 + i));
    m_ready = 1'b1;
    wait_valid("st_wait");
    for (int i = 0; i < 8; i++) begin
      chk("st_valid", 32'(m_valid), 1);
      chk("st_data", 32'(m_data), 32'(8'h10 + i));
      tick();
    end
    chk("st_end_valid", 32'(m_valid), 0);
    chk("st_end_empty", 32'(empty), 1);
    chk("st_end_level", 32'(rd_level), 0);

    // Backpressure with three words pending.
    do_reset();
    push(8'h30); push(8'h31); push(8'h32);
    wait_valid("bp_wait");
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(m_valid), 1);
      chk("bp_data", 32'(m_data), 'h30);
      chk("bp_rd_en", 32'(rd_en), 0);
      chk("bp_level", 32'(rd_level), 2);
      tick();
    end
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_rel_valid", 32'(m_valid), 1);
      chk("bp_rel_data", 32'(m_data), 32'(8'h30 + i));
      tick();
    end
    chk("bp_done", 32'(m_valid), 0);

    // Randomized producer/consumer across many pointer wraps, then drain.
    do_reset();
    ntx = 0; nrd = 0; pg = '0; sd = '0; stall = 0; wrapped = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc < 340 && (wp - ntx) < 8 && $urandom_range(0, 3) != 0) push(W'($urandom));
      m_ready = (cyc >= 340) ? 1'b1 : ($urandom_range(0, 2) != 0);
      #1;
      if (stall) begin
        chk("rnd_hold_valid", 32'(m_valid), 1);
        chk("rnd_hold_data", 32'(m_data), 32'(sd));
      end
      chk("rnd_gray_step", 32'($countones(rd_ptr_gray ^ pg) <= 1), 1);
      pg = rd_ptr_gray;
      if (rd_en) begin
        chk("rnd_read_ptr", 32'(read_ptr), nrd % 16);
        if (nrd % 16 == 15) wrapped = 1;
        nrd++;
      end
      if (m_valid && m_ready) begin
        chk("rnd_q_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          chk("rnd_data_order", 32'(m_data), 32'(exp_q[0]));
          void'(exp_q.pop_front());
        end
        ntx++;
      end
      stall = m_valid && !m_ready;
      sd = m_data;
      tick();
    end
    chk("rnd_all_drained", ntx, wp);
    chk("rnd_wrap_seen", 32'(wrapped), 1);
    chk("rnd_end_valid", 32'(m_valid), 0);
    chk("rnd_end_empty", 32'(empty), 1);
    chk("rnd_end_level", 32'(rd_level), 0);

    // Asynchronous reset between edges while a word is held.
    do_reset();
    push(8'h40); push(8'h41); push(8'h42);
    wait_valid("mr_wait");
    #3;
    rd_arstn = 1'b0;
    wp = 0;
    wr_ptr_gray = '0;
    exp_q.delete();
    #1;
    chk("mr_valid", 32'(m_valid), 0);
    chk("mr_data", 32'(m_data), 0);
    chk("mr_read_ptr", 32'(read_ptr), 0);
    chk("mr_rd_ptr_gray", 32'(rd_ptr_gray), 0);
    chk("mr_empty", 32'(empty), 1);
    chk("mr_rd_en", 32'(rd_en), 0);
    chk("mr_level", 32'(rd_level), 0);
    tick();
    rd_arstn = 1'b1;

    // Corrupted write pointer: level 12 exceeds the depth, flag must stick.
    m_ready = 1'b0;
    wr_ptr_gray = gray(12);
    tick();
    chk("err_not_yet", 32'(ptr_err), 0);
    tick(); tick(); tick();
    chk("err_set", 32'(ptr_err), 1);
    wr_ptr_gray = gray(1);
    tick(); tick(); tick(); tick();
    chk("err_sticky", 32'(ptr_err), 1);
    chk("err_level_back", 32'(rd_level), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
